inst_mem_resp: RTL and testbench
================================

INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, instruction words stored; power of two, minimum 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states per fetch; range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_i  input  1  fetch request from the fetch stage.
REQ-006 SHALL have port addr_i  input  32  fetch byte address, sampled on acceptance.
REQ-007 SHALL have port ready_o  output  1  high when a request can be accepted this cycle.
REQ-008 SHALL have port rdata_o  output  32  fetched instruction; valid only while rvalid_o=1.
REQ-009 SHALL have port rvalid_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port stall_o  output  1  high while an accepted fetch is outstanding (WAIT state).
REQ-011 SHALL have port err_o  output  1  fetch fault flag, qualified by rvalid_o.
REQ-012 SHALL have port ld_we_i  input  1  program-load write enable.
REQ-013 SHALL have port ld_addr_i  input  log2(DEPTH_WORDS)  program-load word index.
REQ-014 SHALL have port ld_data_i  input  32  program-load write data.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, RESP; ready_o=1 in IDLE and RESP, 0 in WAIT.
REQ-016 Acceptance SHALL occur on a rising edge where req_i=1 and ready_o=1; addr_i latched at that edge.
REQ-017 After acceptance: WAIT_CYCLES=0 -> next state RESP; otherwise WAIT with counter loaded to WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0, transition to RESP.
REQ-019 Latency: request accepted at edge N SHALL give rvalid_o=1 for exactly the cycle after edge N+1+WAIT_CYCLES.
REQ-020 In RESP, rvalid_o=1 for one cycle; a request accepted in the same cycle (back-to-back) SHALL start the next fetch with no idle gap; otherwise return to IDLE.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; rdata_o SHALL be registered from the array at the edge entering RESP.
REQ-022 A load write at the edge that enters RESP to the same word SHALL NOT be visible; old data is returned.
REQ-023 Load writes SHALL be accepted in every state and never stall fetches.
REQ-024 stall_o SHALL equal (state == WAIT); it SHALL be 0 when WAIT_CYCLES=0.
REQ-025 rdata_o SHALL hold its last value while rvalid_o=0.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, counter 0, rvalid_o=0, err_o=0, stall_o=0, rdata_o=0x00000000, ready_o=1.
REQ-027 Reset asserted mid-fetch SHALL abort the fetch; no response SHALL be issued after release.
REQ-028 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro INST_MEM_FAULT_CHK_EN defined: a fetch with addr[1:0]!=0 or addr >= 4*DEPTH_WORDS SHALL respond with err_o=1 and rdata_o=0x00000013 (NOP), at normal latency.
REQ-030 Macro undefined: err_o SHALL be tied 0; addr[1:0] and upper address bits SHALL be ignored (index wraps modulo DEPTH_WORDS).

Verification
REQ-031 Load word 5 = 0xDEADBEEF, WAIT_CYCLES=1, fetch addr 0x14 at edge N -> rvalid_o=1 with rdata_o=0xDEADBEEF in the cycle after edge N+2, stall_o=1 for one cycle.
REQ-032 WAIT_CYCLES=0, req_i held high, addrs 0x0, 0x4, 0x8 -> rvalid_o high three consecutive cycles, data words 0, 1, 2 in order.
REQ-033 Word 3 = 0x11111111; load 0x22222222 to word 3 at the edge entering RESP for fetch 0xC -> response 0x11111111; refetch -> 0x22222222.
REQ-034 Pull rst low during WAIT (WAIT_CYCLES=3) -> outputs reset immediately; after release, no rvalid_o pulse, ready_o=1.
REQ-035 With INST_MEM_FAULT_CHK_EN, fetch 0x2 and 0x1000 (DEPTH_WORDS=1024) -> err_o=1, rdata_o=0x00000013; without the macro, fetch 0x1000 -> word 0 data, err_o=0.

Source files
------------

// File: rtl/inst_mem_resp.sv
// Instruction memory with a fixed wait-state fetch FSM and an independent program-load port.
// Build option INST_MEM_FAULT_CHK_EN: misaligned/out-of-range fetches return a NOP with err_o set.
module inst_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_i,
  input  logic [31:0]                    addr_i,
  output logic                           ready_o,
  output logic [31:0]                    rdata_o,
  output logic                           rvalid_o,
  output logic                           stall_o,
  output logic                           err_o,
  input  logic                           ld_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_i,
  input  logic [31:0]                    ld_data_i
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WC_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef INST_MEM_FAULT_CHK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] word_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enter_resp, fetch_fault;
  logic [31:0]   fetch_addr;
  logic [AW-1:0] fetch_idx;

  assign ready_o  = (state_q != WAIT);
  assign stall_o  = (state_q == WAIT);
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  // With no wait states the array is read on the accepting edge, before addr_q is loaded.
  assign accept      = req_i & ready_o;
  assign fetch_addr  = accept ? addr_i : addr_q;
  assign fetch_idx   = fetch_addr[AW+1:2];
  assign fetch_fault = FAULT_EN & ((fetch_addr[1:0] != 2'b00) ||
                                   ((fetch_addr >> (AW + 2)) != 32'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = accept ? addr_i : addr_q;
    case (state_q)
      IDLE, RESP: begin
        if (!accept) begin
          state_d = IDLE;
        end else if (WAIT_CYCLES == 0) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = WC_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP);

  // The response register stage follows the RESP cycle, giving the fixed N+1+WAIT_CYCLES latency.
  always_comb begin
    fault_d  = enter_resp ? fetch_fault : fault_q;
    rvalid_d = (state_q == RESP);
    err_d    = (state_q == RESP) & fault_q;
    rdata_d  = rdata_q;
    if (state_q == RESP) rdata_d = fault_q ? NOP : word_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      fault_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      fault_q  <= fault_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Array is not reset; a same-edge load write is not seen by the read (old data returned).
  always_ff @(posedge clk) begin
    if (ld_we_i)    mem[ld_addr_i] <= ld_data_i;
    if (enter_resp) word_q <= mem[fetch_idx];
  end
endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances (WAIT_CYCLES 1, 0, 3) checked every cycle against
// an edge-counting reference model, plus a directed vector table and hand-written corner sequences.
module tb_inst_mem_resp;
  localparam int          DEPTH = 1024;
  localparam int          NI    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [NI];
  logic [31:0] addr   [NI];
  logic        ready  [NI];
  logic [31:0] rdata  [NI];
  logic        rvalid [NI];
  logic        stall  [NI];
  logic        err    [NI];
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inst_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
      .clk(clk), .rst(rst), .req_i(req[g]), .addr_i(addr[g]), .ready_o(ready[g]),
      .rdata_o(rdata[g]), .rvalid_o(rvalid[g]), .stall_o(stall[g]), .err_o(err[g]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
  end

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];
  int          k = 0;
  bit          acc_v [NI];
  int          last_acc [NI];
  bit          pend_v [NI];
  int          pend_rd [NI];
  logic [31:0] pend_addr [NI];
  bit          resp_v [NI];
  int          resp_e [NI];
  logic [31:0] resp_data [NI];
  bit          resp_err [NI];
  bit          exp_rvalid [NI];
  bit          exp_err [NI];
  logic [31:0] exp_rdata [NI];

  function automatic int wc(int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  function automatic logic [31:0] pat(int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Not ready during the WAIT_CYCLES cycles that follow an acceptance edge.
  function automatic bit m_ready(int g);
    return !(acc_v[g] && k >= last_acc[g] && k < last_acc[g] + wc(g));
  endfunction

  function automatic bit m_fault(logic [31:0] a);
`ifdef INST_MEM_FAULT_CHK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
    return (a === 32'hx);
`endif
  endfunction

  function automatic logic [31:0] m_data(logic [31:0] a);
    return m_fault(a) ? NOP : mem_m[(a / 4) % DEPTH];
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      acc_v[g] = 0; pend_v[g] = 0; resp_v[g] = 0;
      exp_rvalid[g] = 0; exp_err[g] = 0; exp_rdata[g] = 32'd0;
    end
  endtask

  task automatic model_edge();
    bit rdy [NI];
    for (int g = 0; g < NI; g++) rdy[g] = m_ready(g);
    k++;
    if (rst) begin
      for (int g = 0; g < NI; g++) begin
        exp_rvalid[g] = 0;
        exp_err[g]    = 0;
        if (req[g] && rdy[g]) begin
          acc_v[g] = 1; last_acc[g] = k;
          pend_v[g] = 1; pend_rd[g] = k + wc(g); pend_addr[g] = addr[g];
        end
        if (resp_v[g] && resp_e[g] == k) begin
          exp_rvalid[g] = 1; exp_err[g] = resp_err[g]; exp_rdata[g] = resp_data[g];
          resp_v[g] = 0;
        end
        if (pend_v[g] && pend_rd[g] == k) begin
          resp_v[g] = 1; resp_e[g] = k + 1;
          resp_data[g] = m_data(pend_addr[g]); resp_err[g] = m_fault(pend_addr[g]);
          pend_v[g] = 0;
        end
      end
    end
    if (ld_we) mem_m[ld_addr] = ld_data;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t: got %h want %h", name, g, $time, act, expv);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      chk("ready",  g, 32'(ready[g]),  32'(m_ready(g)));
      chk("stall",  g, 32'(stall[g]),  32'(!m_ready(g)));
      chk("rvalid", g, 32'(rvalid[g]), 32'(exp_rvalid[g]));
      chk("err",    g, 32'(err[g]),    32'(exp_err[g]));
      chk("rdata",  g, rdata[g],       exp_rdata[g]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int g = 0; g < NI; g++) begin
      chk("rst_ready", g, 32'(ready[g]), 32'd1);
      chk("rst_rdata", g, rdata[g], 32'd0);
    end
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  task automatic idle();
    for (int g = 0; g < NI; g++) begin req[g] = 1'b0; addr[g] = 32'd0; end
    ld_we = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
  endtask

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          e_rvalid;
    logic [31:0] e_rdata;
    bit          e_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] d_far, d_mis;
    bit          e_far, e_mis;
    idle();
    model_reset();
    #2;
    do_reset(2);

    // program load: pattern everywhere, then the directed words
    for (int i = 0; i < DEPTH; i++) begin
      ld_we = 1'b1; ld_addr = 10'(i); ld_data = pat(i);
      tick();
    end
    ld_addr = 10'd5; ld_data = 32'hDEADBEEF; tick();
    ld_addr = 10'd3; ld_data = 32'h11111111; tick();
    ld_we = 1'b0;
    tick();

    // basic fetch with one wait state
    req[0] = 1'b1; addr[0] = 32'h14; tick();
    chk("w1_stall", 0, 32'(stall[0]), 32'd1);
    chk("w1_rvalid_n", 0, 32'(rvalid[0]), 32'd0);
    req[0] = 1'b0; tick();
    chk("w1_stall_n1", 0, 32'(stall[0]), 32'd0);
    chk("w1_rvalid_n1", 0, 32'(rvalid[0]), 32'd0);
    tick();
    chk("w1_rvalid_n2", 0, 32'(rvalid[0]), 32'd1);
    chk("w1_rdata_n2", 0, rdata[0], 32'hDEADBEEF);
    tick();
    chk("w1_rvalid_end", 0, 32'(rvalid[0]), 32'd0);
    chk("w1_rdata_hold", 0, rdata[0], 32'hDEADBEEF);

    // load write on the edge entering RESP is not visible to that fetch
    req[0] = 1'b1; addr[0] = 32'hC; tick();
    req[0] = 1'b0; ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'h22222222; tick();
    ld_we = 1'b0; tick();
    chk("wr_old", 0, rdata[0], 32'h11111111);
    chk("wr_old_v", 0, 32'(rvalid[0]), 32'd1);
    req[0] = 1'b1; addr[0] = 32'hC; tick();
    req[0] = 1'b0; tick(); tick();
    chk("wr_new", 0, rdata[0], 32'h22222222);

    // back-to-back on the zero-wait instance
`ifdef INST_MEM_FAULT_CHK_EN
    d_far = NOP; e_far = 1'b1; d_mis = NOP; e_mis = 1'b1;
`else
    d_far = pat(0); e_far = 1'b0; d_mis = pat(0); e_mis = 1'b0;
`endif
    tbl[0] = vec_t'{1'b1, 32'h0,    1'b0, 32'd0,  1'b0};
    tbl[1] = vec_t'{1'b1, 32'h4,    1'b1, pat(0), 1'b0};
    tbl[2] = vec_t'{1'b1, 32'h8,    1'b1, pat(1), 1'b0};
    tbl[3] = vec_t'{1'b0, 32'h0,    1'b1, pat(2), 1'b0};
    tbl[4] = vec_t'{1'b0, 32'h0,    1'b0, pat(2), 1'b0};
    tbl[5] = vec_t'{1'b1, 32'h1000, 1'b0, pat(2), 1'b0};
    tbl[6] = vec_t'{1'b1, 32'h2,    1'b1, d_far,  e_far};
    tbl[7] = vec_t'{1'b0, 32'h0,    1'b1, d_mis,  e_mis};
    tbl[8] = vec_t'{1'b0, 32'h0,    1'b0, d_mis,  1'b0};
    for (int i = 0; i < 9; i++) begin
      req[1] = tbl[i].req; addr[1] = tbl[i].addr;
      tick();
      chk("tbl_rvalid", i, 32'(rvalid[1]), 32'(tbl[i].e_rvalid));
      chk("tbl_rdata",  i, rdata[1], tbl[i].e_rdata);
      chk("tbl_err",    i, 32'(err[1]), 32'(tbl[i].e_err));
      chk("tbl_ready",  i, 32'(ready[1]), 32'd1);
    end

    // reset in the middle of a three-wait fetch aborts it
    req[2] = 1'b1; addr[2] = 32'h14; tick();
    req[2] = 1'b0; repeat (4) tick();
    chk("w3_rdata", 2, rdata[2], 32'hDEADBEEF);
    req[2] = 1'b1; addr[2] = 32'h4; tick();
    req[2] = 1'b0; tick();
    chk("w3_stall_mid", 2, 32'(stall[2]), 32'd1);
    do_reset(1);
    chk("w3_rst_stall", 2, 32'(stall[2]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("w3_no_resp", 2, 32'(rvalid[2]), 32'd0);
      chk("w3_ready", 2, 32'(ready[2]), 32'd1);
    end

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      for (int g = 0; g < NI; g++) begin
        req[g] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0:       addr[g] = $urandom();
          1:       addr[g] = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
          2:       addr[g] = 32'($urandom_range(0, DEPTH - 1)) << 2;
          default: addr[g] = 32'($urandom_range(0, 15)) << 2;
        endcase
      end
      ld_we   = ($urandom_range(0, 3) == 0);
      ld_addr = 10'($urandom_range(0, 15));
      ld_data = $urandom();
      if ($urandom_range(0, 249) == 0) do_reset(2);
      else tick();
    end

    idle();
    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
